// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative radix-2 divider.
// State encodings, handshake levels and two's-complement magnitude helpers.
package div_pkg;

  localparam int DATA_W = 32;
  localparam int DOUBLE_W = 2 * DATA_W;
  localparam int WORK_W = DOUBLE_W + 1;
  localparam int CNT_W = 6;

  localparam logic [CNT_W-1:0] DIV_ITERS = 6'd32;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP = 1'b0;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  // Two's-complement negation when en is set; identity otherwise.
  function automatic logic [DATA_W-1:0] neg_if(input logic en, input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] res;
    if (en) begin
      res = ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      res = v;
    end
    return res;
  endfunction

  // Magnitude of v, taken only for signed operation.
  function automatic logic [DATA_W-1:0] abs_if(input logic is_signed, input logic [DATA_W-1:0] v);
    return neg_if(is_signed & v[DATA_W-1], v);
  endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle restoring divider for DIV/DIVU under a start/ready handshake.
// Result is {remainder, quotient}; annul_i cancels an in-flight divide.
module div
  import div_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [DOUBLE_W-1:0] result_o,
  output logic                ready_o
);

  div_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [WORK_W-1:0]   r_work;
  logic [DATA_W-1:0]   r_divisor;
  logic                r_signed;
  logic                r_sign1;
  logic                r_sign2;
  logic [DOUBLE_W-1:0] r_result;
  logic                r_ready;

  div_state_e          w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [WORK_W-1:0]   w_work_nxt;
  logic [DATA_W-1:0]   w_divisor_nxt;
  logic                w_signed_nxt;
  logic                w_sign1_nxt;
  logic                w_sign2_nxt;
  logic [DOUBLE_W-1:0] w_result_nxt;
  logic                w_ready_nxt;

  logic [DATA_W:0]     w_diff;
  logic [DATA_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_rem;

  // Datapath: trial subtraction and sign-corrected final quotient/remainder
  always_comb begin
    w_diff = {1'b0, r_work[DOUBLE_W-1:DATA_W]} - {1'b0, r_divisor};
    w_quot = neg_if(r_signed & (r_sign1 ^ r_sign2), r_work[DATA_W-1:0]);
    w_rem  = neg_if(r_signed & r_sign1, r_work[WORK_W-1:DATA_W+1]);
  end

  // Next-state and next-register logic
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_work_nxt    = r_work;
    w_divisor_nxt = r_divisor;
    w_signed_nxt  = r_signed;
    w_sign1_nxt   = r_sign1;
    w_sign2_nxt   = r_sign2;
    w_result_nxt  = r_result;
    w_ready_nxt   = r_ready;
    case (r_state)
      DIV_FREE: begin
        w_ready_nxt  = DIV_RESULT_NOT_READY;
        w_result_nxt = {DOUBLE_W{1'b0}};
        if ((start_i == DIV_START) && !annul_i) begin
          if (opdata2_i == {DATA_W{1'b0}}) begin
            w_state_nxt = DIV_BYZERO;
          end else begin
            w_state_nxt   = DIV_ON;
            w_cnt_nxt     = {CNT_W{1'b0}};
            w_divisor_nxt = abs_if(signed_div_i, opdata2_i);
            w_signed_nxt  = signed_div_i;
            w_sign1_nxt   = opdata1_i[DATA_W-1];
            w_sign2_nxt   = opdata2_i[DATA_W-1];
            w_work_nxt    = {{DATA_W{1'b0}}, abs_if(signed_div_i, opdata1_i), 1'b0};
          end
        end else begin
          w_state_nxt = DIV_FREE;
        end
      end
      DIV_BYZERO: begin
        w_result_nxt = {DOUBLE_W{1'b0}};
        w_ready_nxt  = DIV_RESULT_READY;
        w_state_nxt  = DIV_END;
      end
      DIV_ON: begin
        if (annul_i) begin
          w_state_nxt  = DIV_FREE;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
          w_result_nxt = {DOUBLE_W{1'b0}};
          w_work_nxt   = {WORK_W{1'b0}};
          w_cnt_nxt    = {CNT_W{1'b0}};
        end else if (r_cnt != DIV_ITERS) begin
          // A borrow means the partial remainder is smaller than the divisor
          if (w_diff[DATA_W]) begin
            w_work_nxt = {r_work[DOUBLE_W-1:0], 1'b0};
          end else begin
            w_work_nxt = {w_diff[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};
          end
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          w_result_nxt = {w_rem, w_quot};
          w_ready_nxt  = DIV_RESULT_READY;
          w_state_nxt  = DIV_END;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          w_state_nxt  = DIV_FREE;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
          w_result_nxt = {DOUBLE_W{1'b0}};
        end else begin
          w_state_nxt = DIV_END;
        end
      end
      default: begin
        w_state_nxt  = DIV_FREE;
        w_ready_nxt  = DIV_RESULT_NOT_READY;
        w_result_nxt = {DOUBLE_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= DIV_FREE;
      r_cnt     <= {CNT_W{1'b0}};
      r_work    <= {WORK_W{1'b0}};
      r_divisor <= {DATA_W{1'b0}};
      r_signed  <= 1'b0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_result  <= {DOUBLE_W{1'b0}};
      r_ready   <= DIV_RESULT_NOT_READY;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_work    <= w_work_nxt;
      r_divisor <= w_divisor_nxt;
      r_signed  <= w_signed_nxt;
      r_sign1   <= w_sign1_nxt;
      r_sign2   <= w_sign2_nxt;
      r_result  <= w_result_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed cases plus randomized divides
// compared against an arithmetic reference model.
module tb_div;

  logic        clk;
  logic        rst;
  logic        sgn;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks;
  int n_pass;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (sgn),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit integer division, truncating toward zero
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] q;
    logic signed [63:0] r;
    if (b == 32'd0) return 64'd0;
    sa = s ? {{32{a[31]}}, a} : {32'd0, a};
    sb = s ? {{32{b[31]}}, b} : {32'd0, b};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    int lat;
    lat = 0;
    @(negedge clk);
    sgn = s; op1 = a; op2 = b; start = 1'b1;
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (ready_o) lat = n;
    end
    check_eq({tag, "_lat"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd34);
    check_eq({tag, "_res"}, result_o, exp);
    @(negedge clk);
    op1 = $urandom; op2 = $urandom; sgn = ~s;
    @(posedge clk); #1;
    check_eq({tag, "_hold"}, {63'd0, ready_o} ^ result_o, exp ^ 64'd1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_drop"}, {63'd0, ready_o} | result_o, 64'd0);
  endtask

  task automatic idle_no_ready(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk); #1;
      if (ready_o) seen++;
    end
    check_eq(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    int          waited;
    n_checks = 0;
    n_pass = 0;
    rst = 1'b0; sgn = 1'b0; op1 = 32'd0; op2 = 32'd0; start = 1'b0; annul = 1'b0;
    #12;
    check_eq("reset_out", {63'd0, ready_o} | result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div("u7d2", 1'b0, 32'd7, 32'd2, 64'h00000001_00000003);
    run_div("s_m7d2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run_div("u_m7d2", 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC);
    run_div("byzero", 1'b1, 32'h12345678, 32'd0, 64'd0);
    run_div("ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run_div("s_7dm2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    run_div("u_maxd1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);

    // Annul during iteration
    @(negedge clk);
    sgn = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk); #1;
    check_eq("annul_out", {63'd0, ready_o} | result_o, 64'd0);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    idle_no_ready("annul_idle", 40);
    run_div("d100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

    // Annul coinciding with start in FREE: request ignored
    @(negedge clk);
    op1 = 32'd9; op2 = 32'd2; start = 1'b1; annul = 1'b1;
    idle_no_ready("annul_free", 4);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    idle_no_ready("annul_free_idle", 40);

    // Async reset mid-iteration
    @(negedge clk);
    sgn = 1'b0; op1 = 32'd50; op2 = 32'd6; start = 1'b1;
    repeat (21) @(posedge clk);
    #3;
    rst = 1'b0; start = 1'b0;
    #1;
    check_eq("rst_mid", {63'd0, ready_o} | result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_no_ready("rst_mid_idle", 40);
    run_div("after_rst", 1'b0, 32'd50, 32'd6, 64'h00000002_00000008);

    // Async reset while a result is held
    @(negedge clk);
    sgn = 1'b1; op1 = 32'hFFFFFF9C; op2 = 32'd7; start = 1'b1;
    waited = 0;
    while (!ready_o && waited < 60) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("end_res", result_o, ref_div(1'b1, 32'hFFFFFF9C, 32'd7));
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_end", {63'd0, ready_o} | result_o, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Randomized divides
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFFFFFF;
        3: b = 32'($urandom_range(1, 15));
        4: b = a;
        default: b = $urandom;
      endcase
      if (i == 0) a = 32'h80000000;
      run_div($sformatf("rnd%0d", i), s, a, b, ref_div(s, a, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div.md
# div

Iterative radix-2 divider controller for the EX stage, executing DIV/DIVU as a multi-cycle operation under a start/ready handshake. EX issues the operands and holds `start_i` while the pipeline controller stalls earlier stages. When the divide completes, `result_o` carries {remainder, quotient}, which EX forwards as {HI, LO} on the HI/LO write path. `annul_i` lets the pipeline flush logic cancel an in-flight divide.

## Interface
- `DATA_W`, 32, operand width (`RegBus`); result is 2·`DATA_W`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `signed_div_i`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `start_i`  in  1  request; held high by EX until it has consumed the result.
- `annul_i`  in  1  cancel the current or pending operation.
- `result_o`  out  64  [63:32] remainder, [31:0] quotient.
- `ready_o`  out  1  result valid.

## Operation
- Registered FSM with states FREE, BYZERO, ON, END. All outputs come from registers.
- Reset (`rst`=0, any state): state FREE, `result_o`=0, `ready_o`=0, counter 0, working register 0.
- **FREE**
  - If `start_i`=1, `annul_i`=0 and `opdata2_i`=0: go to BYZERO.
  - If `start_i`=1, `annul_i`=0 and `opdata2_i`≠0: go to ON, counter 0.
    - Latch `|dividend|` and `|divisor|`; magnitudes are taken only when `signed_div_i`=1.
    - Latch the original operand signs and `signed_div_i`.
    - Working register (65 bits) = {32'b0, |dividend|, 1'b0}.
  - Otherwise stay in FREE with `ready_o`=0 and `result_o`=0.
- **BYZERO**: load `result_o`=0, then go to END.
- **ON**
  - If `annul_i`=1: go to FREE, `ready_o`=0, `result_o`=0, and discard the work.
  - Else, while counter<32, perform one iteration per cycle:
    - Compute `diff` = W[63:32] − |divisor| as a 33-bit subtraction.
    - If `diff` borrows: W = {W[63:0], 1'b0}.
    - Else: W = {diff[31:0], W[31:0], 1'b1}.
    - Counter +1.
  - When counter=32, finish and go to END:
    - Quotient = W[31:0]; remainder = W[64:33].
    - For signed operation, negate the quotient if the operand signs differ, and negate the remainder if the dividend is negative.
    - Load `result_o` = {remainder, quotient} and set `ready_o`=1.
- **END**
  - Hold `result_o` and `ready_o`=1 while `start_i`=1.
  - When `start_i`=0: go to FREE, `ready_o`=0, `result_o`=0.
- Operands are sampled only in FREE; changes to `opdata*_i` in any other state have no effect.
- Signed 0x80000000 / 0xFFFFFFFF produces quotient 0x80000000 (wraps) and remainder 0. This is not an error.
- Divide by zero is not an exception. The result is {0, 0}.

## Timing
- Edge E0 is the edge that samples the accepted `start_i` in FREE.
- Nonzero divisor: iterations occur on E1–E32 and the result loads on E33. `ready_o` is high from E33, i.e. 34 edges after acceptance.
- Zero divisor: BYZERO after E0, END after E1. `ready_o` is high 2 edges after acceptance.
- `ready_o` stays high for every cycle `start_i` remains high in END. It drops on the first edge that samples `start_i`=0.
- Back-to-back divides: a new divide is accepted no earlier than the edge after END→FREE.
- `annul_i` coinciding with `start_i` in FREE: the request is ignored.
- `annul_i` in END or BYZERO: ignored. EX deasserts `start_i` to complete the handshake.
- Async reset mid-operation: outputs clear immediately without waiting for a clock edge. After `rst` deasserts, the block returns to FREE and needs a fresh `start_i`.

## Structure
- Shared `defines.v` holds:
  - State encodings: `DivFree` 2'b00, `DivByZero` 2'b01, `DivOn` 2'b10, `DivEnd` 2'b11.
  - `DivStart`/`DivStop` and `DivResultReady`/`DivResultNotReady`.
  - `DoubleRegBus` (63:0).
- Single module, no sub-module. The subtract/shift step stays inline.
- The stall request to the pipeline controller is generated by EX from `start_i`/`ready_o`, not by this block.

## Test plan
- Unsigned 7 ÷ 2: `start_i` held high → `ready_o` rises 34 edges after acceptance, `result_o`=0x00000001_00000003. Drop `start_i` → `ready_o`=0 next edge.
- Signed 0xFFFFFFF9 ÷ 2: `result_o`=0xFFFFFFFF_FFFFFFFD. Unsigned, same operands: `result_o`=0x00000001_7FFFFFFC.
- Divisor 0, dividend 0x12345678: `ready_o` rises 2 edges after acceptance, `result_o`=0.
- Signed 0x80000000 ÷ 0xFFFFFFFF: `result_o`=0x00000000_80000000.
- Annul: assert `annul_i` 10 cycles into ON → FREE next edge, `ready_o` never rises. A new 100 ÷ 7 then returns 0x00000002_0000000E.
- Async reset: pulse `rst` low at iteration 20 → outputs 0 immediately, FREE after release. A subsequent divide completes normally.
